// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and mode constants for the compare timer
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides the clock into count ticks, one every psc+1 running clocks
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic [PSC_W-1:0] i_psc,
    output logic             o_tick
);

    logic [PSC_W-1:0] cnt_q;
    logic [PSC_W-1:0] cnt_d;

    assign o_tick = i_run && (cnt_q == i_psc);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run) begin
            cnt_d = o_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_cmp.sv
// rtl/timer_cmp.sv - prescaled up-counter with period wrap/one-shot, compare channels and sticky irq flags
module timer_cmp
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int PSC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_mode,
    input  logic [PSC_W-1:0]   i_psc,
    input  logic [WIDTH-1:0]   i_period,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_load_val,
    input  logic [NCH*WIDTH-1:0] i_cmp,
    input  logic [NCH:0]       i_clr,
    input  logic [NCH:0]       i_irq_en,
    output logic [WIDTH-1:0]   o_value,
    output logic               o_tick,
    output logic [NCH-1:0]     o_match,
    output logic               o_wrap,
    output logic [1:0]         o_state,
    output logic               o_irq
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [NCH-1:0]   match_q, match_d, match_set;
    logic             wrap_q, wrap_d;

    logic             psc_tick;
    logic             tick;
    logic             at_top;
    logic             oneshot_stop;
    logic             new_value;
    logic             leave_run;
    logic [WIDTH-1:0] tick_value;

    // A load in the same cycle swallows the tick entirely.
    assign tick         = psc_tick & ~i_load;
    assign at_top       = (value_q >= i_period);
    assign oneshot_stop = at_top && (i_mode == MODE_ONESHOT);
    assign new_value    = tick && !oneshot_stop;
    assign leave_run    = (state_q == RUN) && (state_d != RUN);

    always_comb begin
        tick_value = value_q + 1'b1;
        if (at_top) begin
            tick_value = (i_mode == MODE_PERIODIC) ? '0 : value_q;
        end
    end

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_run   (state_q == RUN),
        .i_clear (i_load | leave_run),
        .i_psc   (i_psc),
        .o_tick  (psc_tick)
    );

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_cmp
            assign match_set[k] = new_value && (tick_value == i_cmp[k*WIDTH +: WIDTH]);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_en) state_d = RUN;
            RUN: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (tick && oneshot_stop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (i_load) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set beats clear on the sticky flags.
    always_comb begin
        value_d = value_q;
        if (i_load) begin
            value_d = i_load_val;
        end else if (tick) begin
            value_d = tick_value;
        end
        wrap_d  = (wrap_q & ~i_clr[NCH]) | (tick & at_top);
        match_d = (match_q & ~i_clr[NCH-1:0]) | match_set;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            value_q <= '0;
            match_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_value = value_q;
    assign o_tick  = tick;
    assign o_match = match_q;
    assign o_wrap  = wrap_q;
    assign o_state = state_q;
    assign o_irq   = |({wrap_q, match_q} & i_irq_en);

endmodule

// File: tb/tb_timer_cmp.sv
// tb/tb_timer_cmp.sv - vector table, corner sequences and randomized model comparison for timer_cmp
module tb_timer_cmp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [7:0]  psc;
    logic [31:0] period;
    logic        load;
    logic [31:0] load_val;
    logic [31:0] cmp0, cmp1;
    logic [2:0]  clr;
    logic [2:0]  irq_en;
    logic [31:0] o_value;
    logic        o_tick;
    logic [1:0]  o_match;
    logic        o_wrap;
    logic [1:0]  o_state;
    logic        o_irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_cmp #(.WIDTH(32), .NCH(2), .PSC_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_mode     (mode),
        .i_psc      (psc),
        .i_period   (period),
        .i_load     (load),
        .i_load_val (load_val),
        .i_cmp      ({cmp1, cmp0}),
        .i_clr      (clr),
        .i_irq_en   (irq_en),
        .o_value    (o_value),
        .o_tick     (o_tick),
        .o_match    (o_match),
        .o_wrap     (o_wrap),
        .o_state    (o_state),
        .o_irq      (o_irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0; load = 1'b0; load_val = '0; clr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_value(input logic [31:0] v, input string name);
        int n = 0;
        while (o_value !== v && n < 200) begin
            step();
            n++;
        end
        chk(name, 64'(o_value), 64'(v));
    endtask

    // Reference model: state 0=idle 1=run 2=done, prescale count as a plain integer.
    int          m_state;
    int          m_pc;
    logic [31:0] m_val;
    logic [1:0]  m_match;
    logic        m_wrap;

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_val = '0; m_match = '0; m_wrap = 1'b0;
    endtask

    task automatic model_check_step();
        logic        ticking, counted, stop;
        logic [31:0] nval;
        logic [1:0]  nmatch;
        logic        nwrap;
        int          nstate;
        ticking = (m_state == 1) && (m_pc == int'(psc));
        counted = ticking && !load;
        chk("rnd_value", 64'(o_value), 64'(m_val));
        chk("rnd_state", 64'(o_state), 64'(m_state));
        chk("rnd_match", 64'(o_match), 64'(m_match));
        chk("rnd_wrap",  64'(o_wrap),  64'(m_wrap));
        chk("rnd_tick",  64'(o_tick),  64'(counted));
        chk("rnd_irq",   64'(o_irq),   64'(|({m_wrap, m_match} & irq_en)));
        stop   = 1'b0;
        nval   = m_val;
        nwrap  = m_wrap & ~clr[2];
        nmatch = m_match & ~clr[1:0];
        if (load) begin
            nval = load_val;
        end else if (counted) begin
            if (m_val >= period) begin
                nwrap = 1'b1;
                if (mode) begin
                    stop = 1'b1;
                end else begin
                    nval = 0;
                    if (cmp0 == 0) nmatch[0] = 1'b1;
                    if (cmp1 == 0) nmatch[1] = 1'b1;
                end
            end else begin
                nval = m_val + 1;
                if (cmp0 == nval) nmatch[0] = 1'b1;
                if (cmp1 == nval) nmatch[1] = 1'b1;
            end
        end
        nstate = m_state;
        if (m_state == 0 && en) nstate = 1;
        else if (m_state == 1 && !en) nstate = 0;
        else if (m_state == 1 && stop) nstate = 2;
        else if (m_state == 2 && !en) nstate = 0;
        else if (m_state == 2 && load) nstate = 1;
        if (load || (m_state == 1 && nstate != 1)) m_pc = 0;
        else if (m_state == 1) m_pc = ticking ? 0 : (m_pc + 1) % 256;
        m_state = nstate;
        m_val   = nval;
        m_match = nmatch;
        m_wrap  = nwrap;
    endtask

    typedef struct {
        logic        mode;
        logic [7:0]  psc;
        logic [31:0] period;
        logic        en;
        int          cycles;
        logic [31:0] exp_value;
        logic [1:0]  exp_state;
        logic        exp_wrap;
        logic [1:0]  exp_match;
    } vec_t;

    vec_t vt[12];

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; psc = '0; period = '0;
        load = 1'b0; load_val = '0; cmp0 = 32'd3; cmp1 = 32'd7; clr = '0; irq_en = '0;
        #1;
        chk("async_reset_value", 64'(o_value), 64'd0);
        chk("async_reset_state", 64'(o_state), 64'd0);

        vt[0]  = '{1'b0, 8'd0, 32'd10,  1'b1, 0,  32'd0,  2'd0, 1'b0, 2'b00};
        vt[1]  = '{1'b0, 8'd0, 32'd10,  1'b1, 5,  32'd4,  2'd1, 1'b0, 2'b01};
        vt[2]  = '{1'b0, 8'd3, 32'd5,   1'b1, 48, 32'd5,  2'd1, 1'b1, 2'b01};
        vt[3]  = '{1'b0, 8'd3, 32'd5,   1'b1, 24, 32'd5,  2'd1, 1'b0, 2'b01};
        vt[4]  = '{1'b0, 8'd3, 32'd5,   1'b1, 25, 32'd0,  2'd1, 1'b1, 2'b01};
        vt[5]  = '{1'b1, 8'd0, 32'd10,  1'b1, 20, 32'd10, 2'd2, 1'b1, 2'b11};
        vt[6]  = '{1'b1, 8'd0, 32'd10,  1'b1, 11, 32'd10, 2'd1, 1'b0, 2'b11};
        vt[7]  = '{1'b0, 8'd0, 32'd0,   1'b1, 4,  32'd0,  2'd1, 1'b1, 2'b00};
        vt[8]  = '{1'b0, 8'd0, 32'd10,  1'b0, 10, 32'd0,  2'd0, 1'b0, 2'b00};
        vt[9]  = '{1'b0, 8'd1, 32'd100, 1'b1, 9,  32'd4,  2'd1, 1'b0, 2'b01};
        vt[10] = '{1'b0, 8'd0, 32'd2,   1'b1, 4,  32'd0,  2'd1, 1'b1, 2'b00};
        vt[11] = '{1'b1, 8'd0, 32'd0,   1'b1, 3,  32'd0,  2'd2, 1'b1, 2'b00};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            mode = vt[i].mode; psc = vt[i].psc; period = vt[i].period; en = vt[i].en;
            repeat (vt[i].cycles) step();
            chk($sformatf("vec%0d_value", i), 64'(o_value), 64'(vt[i].exp_value));
            chk($sformatf("vec%0d_state", i), 64'(o_state), 64'(vt[i].exp_state));
            chk($sformatf("vec%0d_wrap",  i), 64'(o_wrap),  64'(vt[i].exp_wrap));
            chk($sformatf("vec%0d_match", i), 64'(o_match), 64'(vt[i].exp_match));
        end

        // One-shot completes, then a load with enable restarts it.
        do_reset();
        mode = 1'b1; psc = 8'd0; period = 32'd10; en = 1'b1;
        for (int n = 0; n < 50 && o_state !== 2'd2; n++) step();
        chk("oneshot_done_state", 64'(o_state), 64'd2);
        chk("oneshot_done_value", 64'(o_value), 64'd10);
        chk("oneshot_done_wrap",  64'(o_wrap),  64'd1);
        load = 1'b1; load_val = 32'd0;
        step();
        load = 1'b0;
        chk("oneshot_reload_state", 64'(o_state), 64'd1);
        chk("oneshot_reload_value", 64'(o_value), 64'd0);

        // Masked interrupt: only channel 0 reaches o_irq.
        do_reset();
        mode = 1'b0; psc = 8'd0; period = 32'd9; irq_en = 3'b001; en = 1'b1;
        wait_value(32'd2, "irq_reach2");
        chk("irq_before_match", 64'(o_irq), 64'd0);
        wait_value(32'd3, "irq_reach3");
        chk("irq_match0",   64'(o_match), 64'b01);
        chk("irq_asserted", 64'(o_irq),   64'd1);
        wait_value(32'd7, "irq_reach7");
        chk("irq_match1",   64'(o_match), 64'b11);
        chk("irq_held",     64'(o_irq),   64'd1);

        // Clear coinciding with the set event loses; a later clear wins.
        do_reset();
        irq_en = 3'b000; psc = 8'd0; period = 32'd9; en = 1'b1;
        wait_value(32'd2, "clr_reach2");
        clr = 3'b001;
        step();
        clr = 3'b000;
        chk("clr_same_cycle", 64'(o_match[0]), 64'd1);
        clr = 3'b001;
        step();
        clr = 3'b000;
        chk("clr_next_cycle", 64'(o_match[0]), 64'd0);

        // Load beats a simultaneous tick.
        do_reset();
        psc = 8'd3; period = 32'd9; en = 1'b1;
        wait_value(32'd2, "load_reach2");
        for (int n = 0; n < 20 && o_tick !== 1'b1; n++) step();
        chk("load_tick_seen", 64'(o_tick), 64'd1);
        load = 1'b1; load_val = 32'd7;
        #1;
        chk("load_tick_suppressed", 64'(o_tick), 64'd0);
        step();
        load = 1'b0;
        chk("load_value", 64'(o_value), 64'd7);
        chk("load_wrap",  64'(o_wrap),  64'd0);
        chk("load_match", 64'(o_match), 64'd0);

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        psc = 8'd0; period = 32'd9; irq_en = 3'b111; en = 1'b1;
        wait_value(32'd4, "rst_reach4");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_value", 64'(o_value), 64'd0);
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_match", 64'(o_match), 64'd0);
        chk("rst_wrap",  64'(o_wrap),  64'd0);
        chk("rst_tick",  64'(o_tick),  64'd0);
        chk("rst_irq",   64'(o_irq),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0;
        repeat (3) step();
        chk("rst_idle_state", 64'(o_state), 64'd0);
        chk("rst_idle_value", 64'(o_value), 64'd0);
        en = 1'b1;
        step();
        chk("rst_resume_state", 64'(o_state), 64'd1);

        // Randomized run against the reference model.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            model_reset();
            psc    = 8'($urandom_range(0, 3));
            mode   = 1'($urandom_range(0, 1));
            period = $urandom_range(0, 12);
            cmp0   = $urandom_range(0, 12);
            cmp1   = $urandom_range(0, 12);
            irq_en = 3'($urandom_range(0, 7));
            for (int c = 0; c < 300; c++) begin
                en       = ($urandom % 16) != 0;
                load     = ($urandom % 20) == 0;
                load_val = $urandom_range(0, 12);
                clr      = (($urandom % 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
                if (($urandom % 50) == 0) period = $urandom_range(0, 12);
                @(negedge clk);
                model_check_step();
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
